// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - bypass, load-use/mult-div interlock, flush and writeback control for a 5-stage pipe
module pipe_hazard_ctrl #(
    parameter int REG_BITS   = 5,
    parameter int N_READ     = 2,
    parameter int MD_LATENCY = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         d_valid,
    input  logic [N_READ*REG_BITS-1:0]   d_rs,
    input  logic [N_READ-1:0]            d_rs_used,
    input  logic                         d_writes,
    input  logic [REG_BITS-1:0]          d_rd,
    input  logic                         d_is_load,
    input  logic                         d_is_md,
    input  logic                         x_branch_taken,
    output logic                         stall,
    output logic                         flush,
    output logic [2*N_READ-1:0]          x_sel,
    output logic [N_READ-1:0]            d_sel_w,
    output logic                         md_busy,
    output logic                         w_we,
    output logic [REG_BITS-1:0]          w_rd
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 1);

    // X keeps full operand info for forwarding; M and W only need producer fields
    logic                       x_valid, x_writes, x_is_load;
    logic [REG_BITS-1:0]        x_rd;
    logic [N_READ*REG_BITS-1:0] x_rs;
    logic [N_READ-1:0]          x_rs_used;
    logic                       m_valid, m_writes, m_is_load;
    logic [REG_BITS-1:0]        m_rd;
    logic                       w_valid, w_writes;
    logic [CW-1:0]              md_cnt;
    logic                       load_hit, load_use;

    function automatic logic produces(input logic v, input logic wr,
                                      input logic [REG_BITS-1:0] rd,
                                      input logic [REG_BITS-1:0] r);
        return v && wr && (rd == r) && (r != '0);
    endfunction

    always_comb begin
        md_busy  = (md_cnt != '0);
        flush    = x_valid & x_branch_taken & ~md_busy;
        load_hit = 1'b0;
        x_sel    = '0;
        d_sel_w  = '0;
        for (int i = 0; i < N_READ; i++) begin
            if (d_valid && d_rs_used[i] &&
                produces(x_valid & x_is_load, x_writes, x_rd, d_rs[i*REG_BITS +: REG_BITS]))
                load_hit = 1'b1;
            d_sel_w[i] = d_rs_used[i] &
                         produces(w_valid, w_writes, w_rd, d_rs[i*REG_BITS +: REG_BITS]);
            // a load in M has no data yet, so it must not win the M bypass
            if (x_valid && x_rs_used[i]) begin
                if (produces(m_valid, m_writes, m_rd, x_rs[i*REG_BITS +: REG_BITS]) && !m_is_load)
                    x_sel[2*i +: 2] = 2'd1;
                else if (produces(w_valid, w_writes, w_rd, x_rs[i*REG_BITS +: REG_BITS]))
                    x_sel[2*i +: 2] = 2'd2;
            end
        end
        load_use = load_hit & ~md_busy & ~flush;
        stall    = md_busy | load_use;
        w_we     = w_valid & w_writes & (w_rd != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_valid   <= 1'b0;
            x_writes  <= 1'b0;
            x_is_load <= 1'b0;
            x_rd      <= '0;
            x_rs      <= '0;
            x_rs_used <= '0;
            m_valid   <= 1'b0;
            m_writes  <= 1'b0;
            m_is_load <= 1'b0;
            m_rd      <= '0;
            w_valid   <= 1'b0;
            w_writes  <= 1'b0;
            w_rd      <= '0;
            md_cnt    <= '0;
        end else begin
            w_valid  <= m_valid;
            w_writes <= m_writes;
            w_rd     <= m_rd;
            if (md_busy) begin
                m_valid   <= 1'b0;
                m_writes  <= 1'b0;
                m_is_load <= 1'b0;
                m_rd      <= '0;
                md_cnt    <= md_cnt - CW'(1);
            end else begin
                m_valid   <= x_valid;
                m_writes  <= x_writes;
                m_is_load <= x_is_load;
                m_rd      <= x_rd;
                if (flush || load_use) begin
                    x_valid   <= 1'b0;
                    x_writes  <= 1'b0;
                    x_is_load <= 1'b0;
                    x_rd      <= '0;
                    x_rs      <= '0;
                    x_rs_used <= '0;
                end else begin
                    x_valid   <= d_valid;
                    x_writes  <= d_writes;
                    x_is_load <= d_is_load;
                    x_rd      <= d_rd;
                    x_rs      <= d_rs;
                    x_rs_used <= d_rs_used;
                    if (d_valid && d_is_md)
                        md_cnt <= MD_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl at MD_LATENCY 4 and 32
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       d_valid;
    logic [9:0] d_rs;
    logic [1:0] d_rs_used;
    logic       d_writes;
    logic [4:0] d_rd;
    logic       d_is_load;
    logic       d_is_md;
    logic       x_branch_taken;

    logic       stall_a, flush_a, busy_a, we_a;
    logic [3:0] xsel_a;
    logic [1:0] dsel_a;
    logic [4:0] wrd_a;
    logic       stall_b, flush_b, busy_b, we_b;
    logic [3:0] xsel_b;
    logic [1:0] dsel_b;
    logic [4:0] wrd_b;

    pipe_hazard_ctrl #(.REG_BITS(5), .N_READ(2), .MD_LATENCY(4)) u_md4 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
        .d_writes(d_writes), .d_rd(d_rd), .d_is_load(d_is_load), .d_is_md(d_is_md),
        .x_branch_taken(x_branch_taken), .stall(stall_a), .flush(flush_a), .x_sel(xsel_a),
        .d_sel_w(dsel_a), .md_busy(busy_a), .w_we(we_a), .w_rd(wrd_a)
    );

    pipe_hazard_ctrl #(.REG_BITS(5), .N_READ(2), .MD_LATENCY(32)) u_md32 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
        .d_writes(d_writes), .d_rd(d_rd), .d_is_load(d_is_load), .d_is_md(d_is_md),
        .x_branch_taken(x_branch_taken), .stall(stall_b), .flush(flush_b), .x_sel(xsel_b),
        .d_sel_w(dsel_b), .md_busy(busy_b), .w_we(we_b), .w_rd(wrd_b)
    );

    // {stall, flush, md_busy, x_sel[3:0], d_sel_w[1:0], w_we, w_rd[4:0]}
    logic [14:0] obs_a, obs_b;
    assign obs_a = {stall_a, flush_a, busy_a, xsel_a, dsel_a, we_a, wrd_a};
    assign obs_b = {stall_b, flush_b, busy_b, xsel_b, dsel_b, we_b, wrd_b};

    localparam logic [14:0] M_STALL = 15'h4000;
    localparam logic [14:0] M_FLUSH = 15'h2000;
    localparam logic [14:0] M_BUSY  = 15'h1000;
    localparam logic [14:0] M_XSEL  = 15'h0F00;
    localparam logic [14:0] M_DSEL  = 15'h00C0;
    localparam logic [14:0] M_WE    = 15'h0020;
    localparam logic [14:0] M_WRD   = 15'h001F;
    localparam logic [14:0] M_ALL   = 15'h7FFF;

    typedef struct {
        string       tag;
        int          dut;
        logic [14:0] mask;
        logic [14:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [14:0] xs(input logic [3:0] v);
        return {3'b000, v, 8'h00};
    endfunction

    function automatic logic [14:0] ds(input logic [1:0] v);
        return {7'h00, v, 6'h00};
    endfunction

    function automatic logic [14:0] wr(input logic [4:0] rd);
        return {9'h000, 1'b1, rd};
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // dut: 0 = MD_LATENCY 4, 1 = MD_LATENCY 32, 2 = both
    task automatic expect_out(input string tag, input int dut, input logic [14:0] mask,
                              input logic [14:0] val);
        exp_t e;
        e.tag = tag; e.mask = mask; e.val = val & mask;
        if (dut != 1) begin e.dut = 0; sbq.push_back(e); end
        if (dut != 0) begin e.dut = 1; sbq.push_back(e); end
    endtask

    task automatic step();
        @(negedge clock);
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("%s_u%0d", e.tag, e.dut), ((e.dut == 0) ? obs_a : obs_b) & e.mask, e.val);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic ins(input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic wrt, input logic ld, input logic md);
        d_valid = 1'b1; d_rd = rd; d_rs = {rs1, rs0}; d_rs_used = used;
        d_writes = wrt; d_is_load = ld; d_is_md = md;
    endtask

    task automatic nop();
        d_valid = 1'b0; d_rd = '0; d_rs = '0; d_rs_used = '0;
        d_writes = 1'b0; d_is_load = 1'b0; d_is_md = 1'b0;
    endtask

    task automatic drain(input int n);
        nop();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1;
        x_branch_taken = 1'b1;
        nop();
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            d_valid = 1'b1; d_rs = 10'($urandom); d_rs_used = 2'b11; d_writes = 1'b1;
            d_rd = 5'($urandom_range(1, 31)); d_is_load = 1'($urandom); d_is_md = 1'($urandom);
            expect_out("reset_zero", 2, M_ALL, 15'h0);
            step();
        end
        reset = 1'b0;
        x_branch_taken = 1'b0;
        drain(1);

        // distance 1
        ins(3, 1, 2, 2'b11, 1, 0, 0); expect_out("raw1_d", 2, M_STALL | M_XSEL, 0); step();
        ins(4, 3, 3, 2'b11, 1, 0, 0); expect_out("raw1_nostall", 2, M_STALL | M_XSEL, 0); step();
        nop(); expect_out("raw1_xsel", 2, M_STALL | M_XSEL, xs(4'b0101)); step();
        expect_out("raw1_wb", 2, M_WE | M_WRD, wr(3)); step();
        drain(2);

        // distance 2
        ins(3, 1, 2, 2'b11, 1, 0, 0); step();
        ins(10, 1, 2, 2'b11, 1, 0, 0); step();
        ins(4, 3, 3, 2'b11, 1, 0, 0); step();
        nop(); expect_out("raw2_xsel", 2, M_STALL | M_XSEL, xs(4'b1010)); step();
        drain(3);

        // distance 3
        ins(3, 1, 2, 2'b11, 1, 0, 0); step();
        ins(10, 1, 2, 2'b11, 1, 0, 0); step();
        ins(11, 1, 2, 2'b11, 1, 0, 0); step();
        ins(4, 3, 3, 2'b11, 1, 0, 0);
        expect_out("raw3_dsel", 2, M_DSEL | M_XSEL | M_STALL, ds(2'b11)); step();
        nop(); expect_out("raw3_xsel_none", 2, M_XSEL, 0); step();
        drain(3);

        // register 0 never forwards or writes
        ins(0, 1, 2, 2'b11, 1, 0, 0); step();
        ins(4, 0, 0, 2'b11, 1, 0, 0); step();
        nop(); expect_out("r0_xsel", 2, M_XSEL, 0); step();
        ins(14, 0, 0, 2'b11, 1, 0, 0);
        expect_out("r0_we_dsel", 2, M_WE | M_DSEL, 0); step();
        drain(3);

        // load-use
        ins(5, 1, 0, 2'b01, 1, 1, 0); expect_out("lu_load_d", 2, M_STALL, 0); step();
        ins(6, 5, 1, 2'b11, 1, 0, 0); expect_out("lu_stall", 2, M_STALL, M_STALL); step();
        expect_out("lu_release", 2, M_STALL | M_XSEL, 0); step();
        nop(); expect_out("lu_xsel_wb", 2, M_STALL | M_XSEL | M_WE | M_WRD, xs(4'b0010) | wr(5)); step();
        drain(3);

        // taken branch with a load and its user behind it
        ins(0, 1, 2, 2'b11, 0, 0, 0); step();
        ins(9, 1, 0, 2'b01, 1, 1, 0); x_branch_taken = 1'b1;
        expect_out("br_flush", 2, M_FLUSH | M_STALL, M_FLUSH); step();
        ins(13, 9, 9, 2'b11, 1, 0, 0);
        expect_out("br_bubble", 2, M_FLUSH | M_STALL | M_XSEL, 0); step();
        nop(); x_branch_taken = 1'b0; expect_out("br_next", 2, M_STALL | M_FLUSH, 0); step();
        drain(3);

        // mult/div, MD_LATENCY 4 instance
        ins(7, 1, 2, 2'b11, 1, 0, 1); expect_out("md_issue", 2, M_STALL | M_BUSY, 0); step();
        ins(8, 7, 7, 2'b11, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            x_branch_taken = (k == 1);
            expect_out("md_busy", 0, M_BUSY | M_STALL | M_FLUSH, M_BUSY | M_STALL);
            step();
        end
        x_branch_taken = 1'b0;
        expect_out("md_done", 0, M_BUSY | M_STALL | M_XSEL, 0); step();
        nop(); expect_out("md_xsel", 0, M_STALL | M_XSEL, xs(4'b0101)); step();
        drain(3);

        // reset during a MD_LATENCY 32 op
        reset = 1'b1; step();
        reset = 1'b0;
        ins(7, 1, 2, 2'b11, 1, 0, 1); step();
        nop(); expect_out("rm_busy1", 1, M_BUSY | M_STALL, M_BUSY | M_STALL); step();
        reset = 1'b1; expect_out("rm_busy2", 1, M_BUSY, M_BUSY); step();
        reset = 1'b0; expect_out("rm_clear", 1, M_ALL, 0); step();
        ins(12, 1, 2, 2'b11, 1, 0, 0); expect_out("rm_add_d", 1, M_STALL, 0); step();
        nop(); expect_out("rm_add_x", 1, M_STALL | M_BUSY, 0); step();
        step();
        expect_out("rm_add_wb", 1, M_WE | M_WRD, wr(12)); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
